// File: rtl/sr_tx_shift_register_driver.sv
// Serialises a parallel word into a 74HC595-style chain: divided shift clock, MSB-first data, latch pulse, output enable.
// Optional periodic refresh of the last word is enabled by defining SR_TX_REFRESH_EN.
module sr_tx_shift_register_driver #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 500
) (
    input  logic                  clk_50,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  shift_serial_out,
    output logic                  shift_clk,
    output logic                  latch,
    output logic                  out_en_n
);
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(DATA_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   held, held_next;
    logic [DIV_W-1:0]        divider, div_next;
    logic [IDX_W-1:0]        bit_idx, idx_next;
    logic                    ready_next, sclk_next, sout_next, latch_next, oe_n_next;
    logic                    tick;
    logic                    accept;
    logic                    refresh_req;

`ifdef SR_TX_REFRESH_EN
    // Set by the first accepted word; only then is there a meaningful word to resend.
    logic loaded;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            loaded <= 1'b0;
        end else if (accept) begin
            loaded <= 1'b1;
        end
    end

    assign refresh_req = loaded;
`else
    assign refresh_req = 1'b0;
`endif

    assign accept = (state == IDLE) && data_ready && data_valid;

    always_comb begin
        state_next = state;
        held_next  = held;
        div_next   = divider;
        idx_next   = bit_idx;
        ready_next = data_ready;
        sclk_next  = shift_clk;
        sout_next  = shift_serial_out;
        latch_next = latch;
        oe_n_next  = out_en_n;
        tick       = (divider == DIV_LAST);

        case (state)
            IDLE: begin
                div_next   = '0;
                ready_next = 1'b1;
                if (accept) begin
                    held_next  = data_in;
                    state_next = SHIFT;
                    ready_next = 1'b0;
                    idx_next   = IDX_MSB;
                    sout_next  = data_in[DATA_WIDTH-1];
                end else if (data_ready && refresh_req) begin
                    state_next = SHIFT;
                    ready_next = 1'b0;
                    idx_next   = IDX_MSB;
                    sout_next  = held[DATA_WIDTH-1];
                end
            end
            SHIFT: begin
                div_next = tick ? '0 : divider + 1'b1;
                if (tick) begin
                    if (!shift_clk) begin
                        sclk_next = 1'b1;
                    end else if (bit_idx != '0) begin
                        // Data moves on the falling edge so it is stable a full half-period before the next rise.
                        sclk_next = 1'b0;
                        idx_next  = bit_idx - 1'b1;
                        sout_next = held[bit_idx - 1'b1];
                    end else begin
                        sclk_next  = 1'b0;
                        latch_next = 1'b1;
                        state_next = LATCH;
                    end
                end
            end
            LATCH: begin
                div_next = tick ? '0 : divider + 1'b1;
                if (tick) begin
                    latch_next = 1'b0;
                    oe_n_next  = 1'b0;
                    ready_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            held             <= '0;
            divider          <= '0;
            bit_idx          <= IDX_MSB;
            data_ready       <= 1'b0;
            shift_clk        <= 1'b0;
            shift_serial_out <= 1'b0;
            latch            <= 1'b0;
            out_en_n         <= 1'b1;
        end else begin
            state            <= state_next;
            held             <= held_next;
            divider          <= div_next;
            bit_idx          <= idx_next;
            data_ready       <= ready_next;
            shift_clk        <= sclk_next;
            shift_serial_out <= sout_next;
            latch            <= latch_next;
            out_en_n         <= oe_n_next;
        end
    end

endmodule

// File: tb/tb_sr_tx_shift_register_driver.sv
// Directed bench for sr_tx_shift_register_driver: a 16-bit/CLK_DIV=4 instance and a 2-bit/CLK_DIV=2 instance.
module tb_sr_tx_shift_register_driver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [15:0] a_data = '0;
    logic        a_valid = 1'b0;
    logic        a_ready, a_sout, a_sclk, a_latch, a_oe_n;

    logic [1:0]  b_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready, b_sout, b_sclk, b_latch, b_oe_n;

    int checks = 0;
    int failures = 0;

    logic [15:0] cap_bits;
    int          cap_nrise, cap_first, cap_lstart, cap_llen, cap_ready, cap_oefall;
    logic        cap_spacing, cap_sout0;
    logic        ok;

    always #5 clk = ~clk;

    sr_tx_shift_register_driver #(.DATA_WIDTH(16), .CLK_DIV(4)) dut_a (
        .clk_50(clk), .reset_n(reset_n), .data_in(a_data), .data_valid(a_valid),
        .data_ready(a_ready), .shift_serial_out(a_sout), .shift_clk(a_sclk),
        .latch(a_latch), .out_en_n(a_oe_n)
    );

    sr_tx_shift_register_driver #(.DATA_WIDTH(2), .CLK_DIV(2)) dut_b (
        .clk_50(clk), .reset_n(reset_n), .data_in(b_data), .data_valid(b_valid),
        .data_ready(b_ready), .shift_serial_out(b_sout), .shift_clk(b_sclk),
        .latch(b_latch), .out_en_n(b_oe_n)
    );

    // Holds valid until data_ready is seen, then lets one edge accept; returns at T+1 sample point.
    task automatic start_frame(input logic [15:0] w, input logic hold, output logic accepted);
        accepted = 1'b0;
        a_data   = w;
        a_valid  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (a_ready) begin
                @(posedge clk); #1;
                accepted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!hold) a_valid = 1'b0;
    endtask

    // Observes one frame on dut_a starting at offset 0 (just after the accept edge).
    task automatic capture_a(input int plo, input int phi,
                             output logic [15:0] bits, output int nrise, output int first_rise,
                             output logic spacing_ok, output int latch_start, output int latch_len,
                             output int ready_at, output int oe_fall, output logic sout0);
        logic prev;
        int   last;
        bits = '0; nrise = 0; first_rise = -1; spacing_ok = 1'b1;
        latch_start = -1; latch_len = 0; ready_at = -1; oe_fall = -1; last = -1;
        sout0 = a_sout;
        prev  = a_sclk;
        for (int j = 0; j <= 300; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            if (a_sclk && !prev) begin
                if (nrise == 0) first_rise = j;
                else if (j != last + 8) spacing_ok = 1'b0;
                last  = j;
                nrise = nrise + 1;
                bits  = {bits[14:0], a_sout};
            end
            prev = a_sclk;
            if (a_latch) begin
                if (latch_start < 0) latch_start = j;
                latch_len = latch_len + 1;
            end
            if (!a_oe_n && oe_fall < 0) oe_fall = j;
            if (plo >= 0) begin
                if (j >= plo && j <= phi) begin
                    a_valid = 1'b1;
                    a_data  = 16'hFFFF;
                end else begin
                    a_valid = 1'b0;
                end
            end
            if (a_ready) begin
                ready_at = j;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        a_valid = 1'b1; a_data = 16'hFFFF;
        b_valid = 1'b1; b_data = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_ready, a_sclk, a_sout, a_latch, a_oe_n} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_a_outputs got=%b exp=00001", {a_ready, a_sclk, a_sout, a_latch, a_oe_n});
        end
        checks++;
        if ({b_ready, b_sclk, b_sout, b_latch, b_oe_n} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_b_outputs got=%b exp=00001", {b_ready, b_sclk, b_sout, b_latch, b_oe_n});
        end
        a_valid = 1'b0; b_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_first_edge got=%b exp=0", a_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({a_ready, a_oe_n, b_ready, b_oe_n} !== 4'b1111) begin
            failures++;
            $display("FAIL ready_after_release got=%b exp=1111", {a_ready, a_oe_n, b_ready, b_oe_n});
        end
    endtask

    task automatic test_boundary();
        int r1, r2, lstart, llen, rdy, nr;
        logic [1:0] bits;
        logic prev;
        r1 = -1; r2 = -1; lstart = -1; llen = 0; rdy = -1; nr = 0; bits = '0;
        b_data = 2'b10; b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0; b_data = 2'b01;
        prev = b_sclk;
        for (int j = 0; j <= 30; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            if (b_sclk && !prev) begin
                if (nr == 0) r1 = j; else r2 = j;
                nr   = nr + 1;
                bits = {bits[0], b_sout};
            end
            prev = b_sclk;
            if (b_latch) begin
                if (lstart < 0) lstart = j;
                llen = llen + 1;
            end
            if (b_ready) begin
                rdy = j;
                break;
            end
        end
        checks++;
        if (r1 !== 2 || r2 !== 6) begin
            failures++;
            $display("FAIL boundary_rises got=%0d,%0d exp=2,6", r1, r2);
        end
        checks++;
        if (bits !== 2'b10) begin
            failures++;
            $display("FAIL boundary_bits got=%b exp=10", bits);
        end
        checks++;
        if (lstart !== 8 || llen !== 2) begin
            failures++;
            $display("FAIL boundary_latch got=start%0d/len%0d exp=start8/len2", lstart, llen);
        end
        checks++;
        if (rdy !== 10) begin
            failures++;
            $display("FAIL boundary_ready got=%0d exp=10", rdy);
        end
    endtask

    task automatic test_single_frame();
        start_frame(16'hA5C3, 1'b0, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL single_accept got=%b exp=1", ok);
        end
        capture_a(-1, -1, cap_bits, cap_nrise, cap_first, cap_spacing, cap_lstart, cap_llen, cap_ready, cap_oefall, cap_sout0);
        checks++;
        if (cap_sout0 !== 1'b1) begin
            failures++;
            $display("FAIL single_sout_t1 got=%b exp=1", cap_sout0);
        end
        checks++;
        if (cap_bits !== 16'hA5C3 || cap_nrise !== 16) begin
            failures++;
            $display("FAIL single_bits got=%h/%0d rises exp=a5c3/16 rises", cap_bits, cap_nrise);
        end
        checks++;
        if (cap_first !== 4 || cap_spacing !== 1'b1) begin
            failures++;
            $display("FAIL single_rise_timing got=first%0d/spacing%b exp=first4/spacing1", cap_first, cap_spacing);
        end
        checks++;
        if (cap_lstart !== 128 || cap_llen !== 4) begin
            failures++;
            $display("FAIL single_latch got=start%0d/len%0d exp=start128/len4", cap_lstart, cap_llen);
        end
        checks++;
        if (cap_ready !== 132 || cap_oefall !== 132) begin
            failures++;
            $display("FAIL single_ready_oe got=ready%0d/oe%0d exp=ready132/oe132", cap_ready, cap_oefall);
        end
    endtask

    task automatic test_handshake();
        start_frame(16'h3C5A, 1'b0, ok);
        capture_a(5, 40, cap_bits, cap_nrise, cap_first, cap_spacing, cap_lstart, cap_llen, cap_ready, cap_oefall, cap_sout0);
        checks++;
        if (ok !== 1'b1 || cap_sout0 !== 1'b0 || cap_bits !== 16'h3C5A) begin
            failures++;
            $display("FAIL handshake_ignore got=ok%b/sout0%b/%h exp=ok1/sout00/3c5a", ok, cap_sout0, cap_bits);
        end
        checks++;
        if (cap_ready !== 132) begin
            failures++;
            $display("FAIL handshake_ready got=%0d exp=132", cap_ready);
        end
    endtask

    task automatic test_back_to_back();
        start_frame(16'h0001, 1'b1, ok);
        a_data = 16'h8000;
        capture_a(-1, -1, cap_bits, cap_nrise, cap_first, cap_spacing, cap_lstart, cap_llen, cap_ready, cap_oefall, cap_sout0);
        checks++;
        if (cap_bits !== 16'h0001 || cap_ready !== 132) begin
            failures++;
            $display("FAIL b2b_first got=%h/ready%0d exp=0001/ready132", cap_bits, cap_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (a_ready !== 1'b0 || a_sout !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept_133 got=ready%b/sout%b exp=ready0/sout1", a_ready, a_sout);
        end
        a_valid = 1'b0;
        capture_a(-1, -1, cap_bits, cap_nrise, cap_first, cap_spacing, cap_lstart, cap_llen, cap_ready, cap_oefall, cap_sout0);
        checks++;
        if (cap_bits !== 16'h8000 || cap_ready !== 132) begin
            failures++;
            $display("FAIL b2b_second got=%h/ready%0d exp=8000/ready132", cap_bits, cap_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        start_frame(16'hFFFF, 1'b0, ok);
        repeat (54) @(posedge clk);
        #1;
        checks++;
        if (a_sclk !== 1'b1 || a_sout !== 1'b1 || a_oe_n !== 1'b0) begin
            failures++;
            $display("FAIL midreset_pre got=sclk%b/sout%b/oe%b exp=sclk1/sout1/oe0", a_sclk, a_sout, a_oe_n);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({a_ready, a_sclk, a_sout, a_latch, a_oe_n} !== 5'b00001) begin
            failures++;
            $display("FAIL midreset_async got=%b exp=00001", {a_ready, a_sclk, a_sout, a_latch, a_oe_n});
        end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            seen = seen | a_latch | a_sclk;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_latch got=%b exp=0", seen);
        end
        start_frame(16'h1234, 1'b0, ok);
        capture_a(-1, -1, cap_bits, cap_nrise, cap_first, cap_spacing, cap_lstart, cap_llen, cap_ready, cap_oefall, cap_sout0);
        checks++;
        if (ok !== 1'b1 || cap_bits !== 16'h1234 || cap_nrise !== 16) begin
            failures++;
            $display("FAIL midreset_next_frame got=ok%b/%h/%0d exp=ok1/1234/16", ok, cap_bits, cap_nrise);
        end
        checks++;
        if (cap_lstart !== 128 || cap_oefall !== 132) begin
            failures++;
            $display("FAIL midreset_latch_oe got=latch%0d/oe%0d exp=latch128/oe132", cap_lstart, cap_oefall);
        end
    endtask

    task automatic test_refresh();
        start_frame(16'h00FF, 1'b0, ok);
        capture_a(-1, -1, cap_bits, cap_nrise, cap_first, cap_spacing, cap_lstart, cap_llen, cap_ready, cap_oefall, cap_sout0);
        checks++;
        if (cap_bits !== 16'h00FF || cap_ready !== 132) begin
            failures++;
            $display("FAIL refresh_first got=%h/ready%0d exp=00ff/ready132", cap_bits, cap_ready);
        end
        @(posedge clk); #1;
`ifdef SR_TX_REFRESH_EN
        checks++;
        if (a_ready !== 1'b0 || a_sout !== 1'b0) begin
            failures++;
            $display("FAIL refresh_start got=ready%b/sout%b exp=ready0/sout0", a_ready, a_sout);
        end
        capture_a(-1, -1, cap_bits, cap_nrise, cap_first, cap_spacing, cap_lstart, cap_llen, cap_ready, cap_oefall, cap_sout0);
        checks++;
        if (cap_bits !== 16'h00FF || cap_ready !== 132 || cap_lstart !== 128) begin
            failures++;
            $display("FAIL refresh_repeat got=%h/ready%0d/latch%0d exp=00ff/ready132/latch128", cap_bits, cap_ready, cap_lstart);
        end
        @(posedge clk); #1;
        a_data = 16'hFF00; a_valid = 1'b1;
        capture_a(-1, -1, cap_bits, cap_nrise, cap_first, cap_spacing, cap_lstart, cap_llen, cap_ready, cap_oefall, cap_sout0);
        checks++;
        if (cap_bits !== 16'h00FF || cap_ready !== 132) begin
            failures++;
            $display("FAIL refresh_offer_ignored got=%h/ready%0d exp=00ff/ready132", cap_bits, cap_ready);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        checks++;
        if (a_ready !== 1'b0 || a_sout !== 1'b1) begin
            failures++;
            $display("FAIL refresh_new_accept got=ready%b/sout%b exp=ready0/sout1", a_ready, a_sout);
        end
        capture_a(-1, -1, cap_bits, cap_nrise, cap_first, cap_spacing, cap_lstart, cap_llen, cap_ready, cap_oefall, cap_sout0);
        checks++;
        if (cap_bits !== 16'hFF00) begin
            failures++;
            $display("FAIL refresh_new_word got=%h exp=ff00", cap_bits);
        end
`else
        begin
            logic bad;
            bad = 1'b0;
            for (int i = 0; i < 300; i++) begin
                bad = bad | a_sclk | a_latch | !a_ready;
                @(posedge clk); #1;
            end
            checks++;
            if (bad !== 1'b0) begin
                failures++;
                $display("FAIL no_refresh_idle got=%b exp=0", bad);
            end
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_boundary();
        test_single_frame();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        test_refresh();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
